load_buffer: RTL and testbench

Speculative-load tracker on the receiving end of the reorder buffer's memory commit interface. It records the address of every load that has executed but not committed, and watches each store the reorder buffer commits to data memory (`dmem_we`/`store_addr`). When the reorder buffer commits a load whose address was overwritten by an intervening store, the block raises `misload` combinationally in the same cycle. The core uses `misload` to suppress that register write and trigger a refetch. The block sits beside the load unit and hands its allocated entry index to the reorder buffer alongside the load result on cdb3.

---
 rtl/load_buffer_if.sv | 32 +++
 rtl/load_buffer.sv | 81 ++++++++
 tb/tb_load_buffer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/load_buffer_if.sv
// Interface between the load/commit side of the core and load_buffer.
// The misload_count signal is present only when LOADBUF_STATS_EN is defined.
interface load_buffer_if;
  logic        kill;
  logic        loadbuf_en;
  logic [31:0] load_addr;
  logic [2:0]  loadbuf_free_entry;
  logic        loadbuf_full;
  logic [2:0]  loadbuf_commit_entry;
  logic        dmem_we;
  logic [31:0] store_addr;
  logic        misload;
`ifdef LOADBUF_STATS_EN
  logic [15:0] misload_count;
`endif

  modport master (
    output kill, loadbuf_en, load_addr, loadbuf_commit_entry, dmem_we, store_addr,
    input  loadbuf_free_entry, loadbuf_full, misload
`ifdef LOADBUF_STATS_EN
    , input misload_count
`endif
  );

  modport slave (
    input  kill, loadbuf_en, load_addr, loadbuf_commit_entry, dmem_we, store_addr,
    output loadbuf_free_entry, loadbuf_full, misload
`ifdef LOADBUF_STATS_EN
    , output misload_count
`endif
  );
endinterface

// File: rtl/load_buffer.sv
// Speculative-load tracker: flags committed loads whose word was overwritten by a
// committed store. Define LOADBUF_STATS_EN to add the saturating misload_count output.
module load_buffer (
  input  logic          clk,
  input  logic          reset,
  load_buffer_if.slave  lb
);

  logic [7:1]  valid;
  logic [7:1]  hazard;
  logic [31:2] addr [1:7];

  logic [2:0]  free_entry;
  logic        full;
  logic        alloc;
  logic        flush;
  logic        misload;
  logic        store_hits_load;
  logic        unused_low_bits;

  assign unused_low_bits = ^{lb.load_addr[1:0], lb.store_addr[1:0]};

  assign full            = &valid;
  assign alloc           = lb.loadbuf_en && !full;
  assign flush           = reset || lb.kill;
  assign store_hits_load = lb.dmem_we && (lb.store_addr[31:2] == lb.load_addr[31:2]);

  always_comb begin
    free_entry = '0;
    for (int unsigned i = 1; i <= 7; i++) begin
      if (!valid[i] && free_entry == '0)
        free_entry = 3'(i);
    end
  end

  always_comb begin
    misload = 1'b0;
    for (int unsigned i = 1; i <= 7; i++) begin
      if (lb.loadbuf_commit_entry == 3'(i) && valid[i] && hazard[i])
        misload = 1'b1;
    end
  end

  assign lb.loadbuf_free_entry = free_entry;
  assign lb.loadbuf_full       = full;
  assign lb.misload            = misload;

  // Commit clears only a valid entry, so an invalid commit index never blocks an
  // allocation into that same slot.
  always_ff @(posedge clk) begin
    for (int unsigned i = 1; i <= 7; i++) begin
      if (flush) begin
        valid[i]  <= 1'b0;
        hazard[i] <= 1'b0;
      end else if (lb.loadbuf_commit_entry == 3'(i) && valid[i]) begin
        valid[i]  <= 1'b0;
        hazard[i] <= 1'b0;
      end else if (alloc && free_entry == 3'(i)) begin
        valid[i]  <= 1'b1;
        addr[i]   <= lb.load_addr[31:2];
        hazard[i] <= store_hits_load;
      end else if (lb.dmem_we && valid[i] && addr[i] == lb.store_addr[31:2]) begin
        hazard[i] <= 1'b1;
      end
    end
  end

`ifdef LOADBUF_STATS_EN
  logic [15:0] misload_count;

  always_ff @(posedge clk) begin
    if (reset)
      misload_count <= '0;
    else if (!lb.kill && misload && misload_count != '1)
      misload_count <= misload_count + 16'd1;
  end

  assign lb.misload_count = misload_count;
`endif

endmodule

// File: tb/tb_load_buffer.sv
// Scoreboard bench for load_buffer: directed scenarios with constant expectations,
// then a randomized phase checked against a small behavioural model.
module tb_load_buffer;

  logic clk = 1'b0;
  logic reset;

  load_buffer_if lbif ();

  load_buffer dut (
    .clk   (clk),
    .reset (reset),
    .lb    (lbif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] free;
    logic       full;
    logic       mis;
  } exp_t;

  exp_t    exp_q [$];
  int      checks   = 0;
  int      failures = 0;
  logic [15:0] exp_cnt = '0;

  bit [7:0]  mv;
  bit [7:0]  mh;
  bit [29:0] ma [0:7];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic en, input logic [31:0] la,
                     input logic [2:0] c, input logic we, input logic [31:0] sa,
                     input logic kl, input logic [2:0] efree, input logic efull,
                     input logic emis);
    exp_t e;
    lbif.loadbuf_en           = en;
    lbif.load_addr            = la;
    lbif.loadbuf_commit_entry = c;
    lbif.dmem_we              = we;
    lbif.store_addr           = sa;
    lbif.kill                 = kl;
    e.tag  = tag;
    e.free = efree;
    e.full = efull;
    e.mis  = emis;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    check({e.tag, "/free"}, 32'(lbif.loadbuf_free_entry), 32'(e.free));
    check({e.tag, "/full"}, 32'(lbif.loadbuf_full), 32'(e.full));
    check({e.tag, "/misload"}, 32'(lbif.misload), 32'(e.mis));
`ifdef LOADBUF_STATS_EN
    check({e.tag, "/count"}, 32'(lbif.misload_count), 32'(exp_cnt));
    if (!kl && e.mis && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic [2:0] efree, input logic efull);
    cyc(tag, 1'b0, '0, 3'd0, 1'b0, '0, 1'b0, efree, efull, 1'b0);
  endtask

  initial begin
    lbif.loadbuf_en = 1'b0; lbif.load_addr = '0; lbif.loadbuf_commit_entry = '0;
    lbif.dmem_we = 1'b0; lbif.store_addr = '0; lbif.kill = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_cnt = '0;

    idle("reset_idle", 3'd1, 1'b0);

    // basic allocate / commit
    cyc("alloc_100", 1, 32'h100, 0, 0, 0, 0, 3'd1, 0, 0);
    cyc("alloc_200", 1, 32'h200, 0, 0, 0, 0, 3'd2, 0, 0);
    cyc("commit1_clean", 0, 0, 1, 0, 0, 0, 3'd3, 0, 0);
    idle("freed1", 3'd1, 1'b0);

    // byte store within the same word conflicts
    cyc("alloc_104", 1, 32'h104, 0, 0, 0, 0, 3'd1, 0, 0);
    cyc("store_106", 0, 0, 0, 1, 32'h106, 0, 3'd3, 0, 0);
    cyc("commit1_hazard", 0, 0, 1, 0, 0, 0, 3'd3, 0, 1);

    // store to the neighbouring word does not
    cyc("realloc_104", 1, 32'h104, 0, 0, 0, 0, 3'd1, 0, 0);
    cyc("store_108", 0, 0, 0, 1, 32'h108, 0, 3'd3, 0, 0);
    cyc("commit1_nohaz", 0, 0, 1, 0, 0, 0, 3'd3, 0, 0);

    // store committing in the allocation cycle counts as intervening
    cyc("alloc_300_st", 1, 32'h300, 0, 1, 32'h300, 0, 3'd1, 0, 0);
    cyc("commit1_same", 0, 0, 1, 0, 0, 0, 3'd3, 0, 1);

    // fill to capacity (entry 2 still holds 0x200)
    cyc("fill1", 1, 32'h500, 0, 0, 0, 0, 3'd1, 0, 0);
    cyc("fill3", 1, 32'h600, 0, 0, 0, 0, 3'd3, 0, 0);
    cyc("fill4", 1, 32'h700, 0, 0, 0, 0, 3'd4, 0, 0);
    cyc("fill5", 1, 32'h800, 0, 0, 0, 0, 3'd5, 0, 0);
    cyc("fill6", 1, 32'h900, 0, 0, 0, 0, 3'd6, 0, 0);
    cyc("fill7", 1, 32'hA00, 0, 0, 0, 0, 3'd7, 0, 0);
    idle("full", 3'd0, 1'b1);
    cyc("alloc_when_full", 1, 32'hB00, 0, 0, 0, 0, 3'd0, 1, 0);
    idle("still_full", 3'd0, 1'b1);
    cyc("commit4_full", 0, 0, 4, 0, 0, 0, 3'd0, 1, 0);
    idle("after_commit4", 3'd4, 1'b0);

    // hazard 2 and 3, then kill; misload in kill cycle uses pre-flush state
    cyc("store_200", 0, 0, 0, 1, 32'h200, 0, 3'd4, 0, 0);
    cyc("store_600", 0, 0, 0, 1, 32'h603, 0, 3'd4, 0, 0);
    cyc("kill_commit3", 0, 0, 3, 0, 0, 1, 3'd4, 0, 1);
    idle("after_kill", 3'd1, 1'b0);
    cyc("commit2_killed", 0, 0, 2, 0, 0, 0, 3'd1, 0, 0);

    // randomized phase against a behavioural model (buffer is empty here)
    mv = '0; mh = '0;
    for (int n = 0; n < 400; n++) begin
      logic [2:0]  f, c;
      logic        fl, en, we, kl, emis;
      logic [31:0] la, sa;
      f = '0;
      for (int i = 1; i <= 7; i++) if (!mv[i] && f == '0) f = 3'(i);
      fl   = (mv[7:1] == 7'h7F);
      c    = 3'($urandom_range(0, 7));
      we   = ($urandom_range(0, 2) == 0);
      en   = !fl && ($urandom_range(0, 1) == 1);
      kl   = ($urandom_range(0, 49) == 0);
      la   = 32'h40 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
      sa   = 32'h40 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
      emis = (c != 0) && mv[c] && mh[c];
      cyc("rand", en, la, c, we, sa, kl, f, fl, emis);
      if (kl) begin
        mv = '0; mh = '0;
      end else begin
        if (c != 0 && mv[c]) begin
          mv[c] = 1'b0; mh[c] = 1'b0;
        end
        for (int i = 1; i <= 7; i++)
          if (we && mv[i] && ma[i] == sa[31:2]) mh[i] = 1'b1;
        if (en && f != 0) begin
          mv[f] = 1'b1;
          ma[f] = la[31:2];
          mh[f] = we && (sa[31:2] == la[31:2]);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
